// File: rtl/cpu_types_pkg.sv
// Shared types for the PC redirect path: next-PC select encoding and controller states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        PC_NEXT = 2'd0,
        PC_BR   = 2'd1,
        PC_JR   = 2'd2,
        PC_J    = 2'd3
    } pc_sel_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_HALT = 2'd2
    } pcc_state_t;

    localparam int ADDR_W = 32;
    localparam int JTGT_W = 26;

    // Gates an operand onto its output only when it belongs to the active select.
    function automatic logic [ADDR_W-1:0] sel_operand(input pc_sel_t sel,
                                                      input pc_sel_t want,
                                                      input logic [ADDR_W-1:0] op);
        return (sel == want) ? op : '0;
    endfunction

endpackage

// File: rtl/redirect_arb.sv
// Combinational priority encoder for redirect requests: branch > jr > jump.
module redirect_arb
    import cpu_types_pkg::*;
(
    input  logic              i_br_req,
    input  logic [ADDR_W-1:0] i_br_off,
    input  logic              i_jr_req,
    input  logic [ADDR_W-1:0] i_jr_addr,
    input  logic              i_j_req,
    input  logic [JTGT_W-1:0] i_j_tgt,
    output logic              o_valid,
    output pc_sel_t           o_sel,
    output logic [ADDR_W-1:0] o_op,
    output logic [ADDR_W-1:0] o_ext32,
    output logic [ADDR_W-1:0] o_jr_a,
    output logic [JTGT_W-1:0] o_jump_a
);

    logic [ADDR_W-1:0] w_jump_ext;

    assign w_jump_ext = {{(ADDR_W-JTGT_W){1'b0}}, i_j_tgt};

    always_comb begin
        o_valid = 1'b0;
        o_sel   = PC_NEXT;
        o_op    = '0;
        if (i_br_req) begin
            o_valid = 1'b1;
            o_sel   = PC_BR;
            o_op    = i_br_off;
        end else if (i_jr_req) begin
            o_valid = 1'b1;
            o_sel   = PC_JR;
            o_op    = i_jr_addr;
        end else if (i_j_req) begin
            o_valid = 1'b1;
            o_sel   = PC_J;
            o_op    = w_jump_ext;
        end
    end

    logic [ADDR_W-1:0] w_jump_sel;

    assign o_ext32    = sel_operand(o_sel, PC_BR, o_op);
    assign o_jr_a     = sel_operand(o_sel, PC_JR, o_op);
    assign w_jump_sel = sel_operand(o_sel, PC_J, o_op);
    assign o_jump_a   = w_jump_sel[JTGT_W-1:0];

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencer: arbitrates redirects, holds them across I-cache misses,
// runs the halt sequence and counts accepted redirects.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | normal fetch; winning request accepted on ihit, else latched
//   ST_PEND | redirect latched, waiting for ihit; new requests ignored
//   ST_HALT | core halted, pc_ihit masked; left only through reset
module pc_redirect_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              br_req,
    input  logic [31:0]       br_off,
    input  logic              jr_req,
    input  logic [31:0]       jr_addr,
    input  logic              j_req,
    input  logic [25:0]       j_tgt,
    input  logic              halt,
    input  logic              ihit,
    output logic [1:0]        pc_sel,
    output logic [31:0]       ext32,
    output logic [31:0]       jr_a,
    output logic [25:0]       jump_a,
    output logic              pc_ihit,
    output logic              flush,
    output logic              pend,
    output logic              halted,
    output logic [CNT_W-1:0]  redirect_cnt
);

    pcc_state_t        r_state;
    pc_sel_t           r_pend_sel;
    logic [ADDR_W-1:0] r_pend_op;
    logic              r_halt_pend;
    logic              r_pend;
    logic              r_halted;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_arb_valid;
    pc_sel_t           w_arb_sel;
    logic [ADDR_W-1:0] w_arb_op;
    logic [ADDR_W-1:0] w_arb_ext32;
    logic [ADDR_W-1:0] w_arb_jr_a;
    logic [JTGT_W-1:0] w_arb_jump_a;
    logic [ADDR_W-1:0] w_pend_jump;
    logic              w_accept;

    redirect_arb u_arb (
        .i_br_req  (br_req),
        .i_br_off  (br_off),
        .i_jr_req  (jr_req),
        .i_jr_addr (jr_addr),
        .i_j_req   (j_req),
        .i_j_tgt   (j_tgt),
        .o_valid   (w_arb_valid),
        .o_sel     (w_arb_sel),
        .o_op      (w_arb_op),
        .o_ext32   (w_arb_ext32),
        .o_jr_a    (w_arb_jr_a),
        .o_jump_a  (w_arb_jump_a)
    );

    assign w_pend_jump = sel_operand(r_pend_sel, PC_J, r_pend_op);

    always_comb begin
        pc_sel   = PC_NEXT;
        ext32    = '0;
        jr_a     = '0;
        jump_a   = '0;
        w_accept = 1'b0;
        case (r_state)
            ST_RUN: begin
                pc_sel   = w_arb_sel;
                ext32    = w_arb_ext32;
                jr_a     = w_arb_jr_a;
                jump_a   = w_arb_jump_a;
                w_accept = w_arb_valid & ihit;
            end
            ST_PEND: begin
                pc_sel   = r_pend_sel;
                ext32    = sel_operand(r_pend_sel, PC_BR, r_pend_op);
                jr_a     = sel_operand(r_pend_sel, PC_JR, r_pend_op);
                jump_a   = w_pend_jump[JTGT_W-1:0];
                w_accept = ihit;
            end
            default: ;
        endcase
    end

    assign flush        = w_accept;
    assign pc_ihit      = ihit & (r_state != ST_HALT);
    assign pend         = r_pend;
    assign halted       = r_halted;
    assign redirect_cnt = r_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= ST_RUN;
            r_pend_sel  <= PC_NEXT;
            r_pend_op   <= '0;
            r_halt_pend <= 1'b0;
            r_pend      <= 1'b0;
            r_halted    <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_arb_valid) begin
                        if (ihit) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            // A halt arriving with an accepted redirect retires right behind it.
                            if (halt) begin
                                r_state  <= ST_HALT;
                                r_halted <= 1'b1;
                            end
                        end else begin
                            r_pend_sel  <= w_arb_sel;
                            r_pend_op   <= w_arb_op;
                            r_halt_pend <= halt;
                            r_pend      <= 1'b1;
                            r_state     <= ST_PEND;
                        end
                    end else if (halt) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (ihit) begin
                        r_cnt       <= r_cnt + CNT_W'(1);
                        r_pend      <= 1'b0;
                        r_pend_sel  <= PC_NEXT;
                        r_pend_op   <= '0;
                        r_halt_pend <= 1'b0;
                        if (r_halt_pend || halt) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end else if (halt) begin
                        r_halt_pend <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: expected redirects are queued when driven
// and compared against the PC-side outputs in the cycle flush reports the accept.
module tb_pc_redirect_ctrl;

    logic        CLK;
    logic        nRST;
    logic        br_req;
    logic [31:0] br_off;
    logic        jr_req;
    logic [31:0] jr_addr;
    logic        j_req;
    logic [25:0] j_tgt;
    logic        halt;
    logic        ihit;
    logic [1:0]  pc_sel;
    logic [31:0] ext32;
    logic [31:0] jr_a;
    logic [25:0] jump_a;
    logic        pc_ihit;
    logic        flush;
    logic        pend;
    logic        halted;
    logic [3:0]  redirect_cnt;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] op;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] exp_cnt;
    int         pass_cnt;
    int         total_cnt;

    pc_redirect_ctrl #(.CNT_W(4)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .br_req       (br_req),
        .br_off       (br_off),
        .jr_req       (jr_req),
        .jr_addr      (jr_addr),
        .j_req        (j_req),
        .j_tgt        (j_tgt),
        .halt         (halt),
        .ihit         (ihit),
        .pc_sel       (pc_sel),
        .ext32        (ext32),
        .jr_a         (jr_a),
        .jump_a       (jump_a),
        .pc_ihit      (pc_ihit),
        .flush        (flush),
        .pend         (pend),
        .halted       (halted),
        .redirect_cnt (redirect_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_reqs();
        br_req = 0; br_off = '0; jr_req = 0; jr_addr = '0; j_req = 0; j_tgt = '0; halt = 0;
    endtask

    task automatic apply_reset();
        clear_reqs();
        ihit = 0;
        nRST = 0;
        #3;
        nRST = 1;
        step();
        sb.delete();
        exp_cnt = '0;
    endtask

    // Pops the oldest expected redirect and compares it with what the PC sees now.
    task automatic pop_and_compare(input string tag);
        exp_t e;
        logic [31:0] w_ext, w_jr;
        logic [25:0] w_j;
        total_cnt++;
        if (sb.size() == 0) begin
            $display("FAIL %s scoreboard empty at accept", tag);
            return;
        end
        pass_cnt++;
        e = sb.pop_front();
        w_ext = (e.sel == 2'd1) ? e.op : 32'd0;
        w_jr  = (e.sel == 2'd2) ? e.op : 32'd0;
        w_j   = (e.sel == 2'd3) ? e.op[25:0] : 26'd0;
        total_cnt++;
        if (pc_sel !== e.sel) $display("FAIL %s pc_sel got %0d want %0d", tag, pc_sel, e.sel);
        else pass_cnt++;
        total_cnt++;
        if (ext32 !== w_ext) $display("FAIL %s ext32 got %h want %h", tag, ext32, w_ext);
        else pass_cnt++;
        total_cnt++;
        if (jr_a !== w_jr) $display("FAIL %s jr_a got %h want %h", tag, jr_a, w_jr);
        else pass_cnt++;
        total_cnt++;
        if (jump_a !== w_j) $display("FAIL %s jump_a got %h want %h", tag, jump_a, w_j);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        clear_reqs();
        ihit = 1;
        nRST = 0;
        #2;
        total_cnt++;
        if ({pc_sel, flush, pend, halted, redirect_cnt} !== 9'd0)
            $display("FAIL reset_outs got sel=%0d fl=%b pe=%b ha=%b cnt=%0d want all 0",
                     pc_sel, flush, pend, halted, redirect_cnt);
        else pass_cnt++;
        total_cnt++;
        if (pc_ihit !== 1'b1) $display("FAIL reset_pc_ihit got %b want 1", pc_ihit);
        else pass_cnt++;
        ihit = 0;
        #1;
        total_cnt++;
        if (pc_ihit !== 1'b0) $display("FAIL reset_pc_ihit_low got %b want 0", pc_ihit);
        else pass_cnt++;
        nRST = 1;
        step();
        exp_cnt = '0;
    endtask

    task automatic test_branch_hit();
        br_req = 1; br_off = 32'h10; ihit = 1;
        sb.push_back('{2'd1, 32'h10});
        #1;
        total_cnt++;
        if (flush !== 1'b1) $display("FAIL br_hit_flush got %b want 1", flush);
        else pass_cnt++;
        pop_and_compare("br_hit");
        step();
        exp_cnt++;
        clear_reqs();
        #1;
        total_cnt++;
        if (redirect_cnt !== exp_cnt) $display("FAIL br_hit_cnt got %0d want %0d", redirect_cnt, exp_cnt);
        else pass_cnt++;
        total_cnt++;
        if (flush !== 1'b0 || pc_sel !== 2'd0) $display("FAIL br_hit_idle got fl=%b sel=%0d want 0/0", flush, pc_sel);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        br_req = 1; br_off = 32'h20; jr_req = 1; jr_addr = 32'h400; j_req = 1; j_tgt = 26'h3ff; ihit = 1;
        sb.push_back('{2'd1, 32'h20});
        #1;
        pop_and_compare("prio_all");
        step();
        exp_cnt++;
        br_req = 0;
        sb.push_back('{2'd2, 32'h400});
        #1;
        total_cnt++;
        if (flush !== 1'b1) $display("FAIL b2b_jr_flush got %b want 1", flush);
        else pass_cnt++;
        pop_and_compare("prio_jr");
        step();
        exp_cnt++;
        jr_req = 0;
        sb.push_back('{2'd3, 32'h3ff});
        #1;
        pop_and_compare("prio_j");
        step();
        exp_cnt++;
        clear_reqs();
        #1;
        total_cnt++;
        if (redirect_cnt !== exp_cnt) $display("FAIL b2b_cnt got %0d want %0d", redirect_cnt, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_miss_hold();
        j_req = 1; j_tgt = 26'h123; ihit = 0;
        sb.push_back('{2'd3, 32'h123});
        #1;
        total_cnt++;
        if (pc_sel !== 2'd3 || jump_a !== 26'h123 || flush !== 1'b0 || pend !== 1'b0)
            $display("FAIL miss_c1 got sel=%0d ja=%h fl=%b pe=%b want 3/123/0/0", pc_sel, jump_a, flush, pend);
        else pass_cnt++;
        for (int c = 2; c <= 3; c++) begin
            step();
            clear_reqs();
            br_req = 1; br_off = 32'h55;
            #1;
            total_cnt++;
            if (pend !== 1'b1 || pc_sel !== 2'd3 || jump_a !== 26'h123 || flush !== 1'b0 || ext32 !== 32'd0)
                $display("FAIL miss_hold_c%0d got pe=%b sel=%0d ja=%h fl=%b ext=%h want 1/3/123/0/0",
                         c, pend, pc_sel, jump_a, flush, ext32);
            else pass_cnt++;
        end
        step();
        clear_reqs();
        ihit = 1;
        #1;
        total_cnt++;
        if (flush !== 1'b1) $display("FAIL miss_accept_flush got %b want 1", flush);
        else pass_cnt++;
        pop_and_compare("miss_accept");
        step();
        exp_cnt++;
        total_cnt++;
        if (pend !== 1'b0 || flush !== 1'b0 || redirect_cnt !== exp_cnt)
            $display("FAIL miss_after got pe=%b fl=%b cnt=%0d want 0/0/%0d", pend, flush, redirect_cnt, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_counter_wrap();
        int k;
        logic miss;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            k = $urandom_range(0, 2);
            miss = (i % 4 == 1);
            clear_reqs();
            case (k)
                0: begin br_req = 1; br_off = $urandom; sb.push_back('{2'd1, br_off}); end
                1: begin jr_req = 1; jr_addr = $urandom; sb.push_back('{2'd2, jr_addr}); end
                default: begin j_req = 1; j_tgt = 26'($urandom); sb.push_back('{2'd3, {6'd0, j_tgt}}); end
            endcase
            ihit = !miss;
            if (miss) begin
                #1;
                total_cnt++;
                if (flush !== 1'b0) $display("FAIL wrap_miss_flush i=%0d got %b want 0", i, flush);
                else pass_cnt++;
                step();
                clear_reqs();
                ihit = 1;
            end
            #1;
            total_cnt++;
            if (flush !== 1'b1) $display("FAIL wrap_flush i=%0d got %b want 1", i, flush);
            else pass_cnt++;
            pop_and_compare("wrap");
            step();
            exp_cnt++;
            clear_reqs();
        end
        #1;
        total_cnt++;
        if (redirect_cnt !== 4'd1 || redirect_cnt !== exp_cnt)
            $display("FAIL wrap_cnt got %0d want 1 (model %0d)", redirect_cnt, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_pend();
        j_req = 1; j_tgt = 26'h2a; ihit = 0;
        step();
        clear_reqs();
        #1;
        total_cnt++;
        if (pend !== 1'b1 || redirect_cnt !== exp_cnt)
            $display("FAIL rst_pend_pre got pe=%b cnt=%0d want 1/%0d", pend, redirect_cnt, exp_cnt);
        else pass_cnt++;
        nRST = 0;
        #1;
        total_cnt++;
        if (pend !== 1'b0 || pc_sel !== 2'd0 || redirect_cnt !== 4'd0 || jump_a !== 26'd0)
            $display("FAIL rst_pend_async got pe=%b sel=%0d cnt=%0d ja=%h want 0/0/0/0",
                     pend, pc_sel, redirect_cnt, jump_a);
        else pass_cnt++;
        #2;
        nRST = 1;
        sb.delete();
        exp_cnt = '0;
        step();
        ihit = 1;
        #1;
        total_cnt++;
        if (pend !== 1'b0 || flush !== 1'b0) $display("FAIL rst_pend_idle got pe=%b fl=%b want 0/0", pend, flush);
        else pass_cnt++;
        jr_req = 1; jr_addr = 32'h8000_0040;
        sb.push_back('{2'd2, 32'h8000_0040});
        #1;
        total_cnt++;
        if (flush !== 1'b1) $display("FAIL rst_pend_run_flush got %b want 1", flush);
        else pass_cnt++;
        pop_and_compare("rst_pend_run");
        step();
        exp_cnt++;
        clear_reqs();
        total_cnt++;
        if (redirect_cnt !== exp_cnt) $display("FAIL rst_pend_cnt got %0d want %0d", redirect_cnt, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_halt_pend();
        j_req = 1; j_tgt = 26'h77; ihit = 0;
        sb.push_back('{2'd3, 32'h77});
        step();
        clear_reqs();
        halt = 1;
        step();
        halt = 0;
        #1;
        total_cnt++;
        if (pend !== 1'b1 || halted !== 1'b0) $display("FAIL halt_pend_wait got pe=%b ha=%b want 1/0", pend, halted);
        else pass_cnt++;
        ihit = 1;
        #1;
        total_cnt++;
        if (flush !== 1'b1) $display("FAIL halt_pend_flush got %b want 1", flush);
        else pass_cnt++;
        pop_and_compare("halt_pend_accept");
        step();
        exp_cnt++;
        br_req = 1; br_off = 32'h99;
        for (int c = 0; c < 2; c++) begin
            #1;
            total_cnt++;
            if (halted !== 1'b1 || pend !== 1'b0 || pc_ihit !== 1'b0 || pc_sel !== 2'd0 || flush !== 1'b0 || ext32 !== 32'd0)
                $display("FAIL halt_state c%0d got ha=%b pe=%b pi=%b sel=%0d fl=%b ext=%h want 1/0/0/0/0/0",
                         c, halted, pend, pc_ihit, pc_sel, flush, ext32);
            else pass_cnt++;
            total_cnt++;
            if (redirect_cnt !== exp_cnt) $display("FAIL halt_cnt c%0d got %0d want %0d", c, redirect_cnt, exp_cnt);
            else pass_cnt++;
            step();
        end
        clear_reqs();
    endtask

    task automatic test_halt_run();
        apply_reset();
        halt = 1; ihit = 1;
        #1;
        total_cnt++;
        if (pc_ihit !== 1'b1 || halted !== 1'b0 || flush !== 1'b0)
            $display("FAIL halt_run_pre got pi=%b ha=%b fl=%b want 1/0/0", pc_ihit, halted, flush);
        else pass_cnt++;
        step();
        halt = 0;
        j_req = 1; j_tgt = 26'h155;
        #1;
        total_cnt++;
        if (halted !== 1'b1 || pc_ihit !== 1'b0 || pc_sel !== 2'd0 || flush !== 1'b0 || jump_a !== 26'd0)
            $display("FAIL halt_run got ha=%b pi=%b sel=%0d fl=%b ja=%h want 1/0/0/0/0",
                     halted, pc_ihit, pc_sel, flush, jump_a);
        else pass_cnt++;
        step();
        total_cnt++;
        if (redirect_cnt !== 4'd0 || halted !== 1'b1)
            $display("FAIL halt_run_hold got cnt=%0d ha=%b want 0/1", redirect_cnt, halted);
        else pass_cnt++;
        clear_reqs();
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        exp_cnt = '0;
        clear_reqs();
        ihit = 0;
        nRST = 0;
        test_reset();
        test_branch_hit();
        test_back_to_back();
        test_miss_hold();
        test_counter_wrap();
        test_reset_mid_pend();
        test_halt_pend();
        test_halt_run();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
